// File: rtl/mem_responder_if.sv
// Request/response memory port between the multicycle core (master) and its memory (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory with a valid/ready port, configurable wait states,
// byte-lane stores and aligned, extended loads.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, enter_resp;

    logic        cap_we, cap_unsigned;
    logic [31:0] cap_addr, cap_wdata;
    logic [1:0]  cap_size;

    logic        cur_we, cur_unsigned;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem_word, shifted, load_data, rdata_nxt, wdata_rep;
    logic [3:0]       lanes;
    logic             err;

    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    function automatic logic [31:0] extend(input logic [15:0] val, input logic is_half,
                                           input logic uns);
        logic [31:0] res;
        if (is_half) res = uns ? {16'h0, val} : {{16{val[15]}}, val};
        else         res = uns ? {24'h0, val[7:0]} : {{24{val[7]}}, val[7:0]};
        return res;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // With zero wait states the response is built on the acceptance edge, so the live
    // request is used before it has been captured.
    assign cur_we       = (state == IDLE) ? bus.req_we       : cap_we;
    assign cur_addr     = (state == IDLE) ? bus.req_addr     : cap_addr;
    assign cur_size     = (state == IDLE) ? bus.req_size     : cap_size;
    assign cur_unsigned = (state == IDLE) ? bus.req_unsigned : cap_unsigned;
    assign cur_wdata    = (state == IDLE) ? bus.req_wdata    : cap_wdata;

    assign err = (cur_size == 2'b11)
               || (cur_size == 2'b01 && cur_addr[0])
               || (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)
               || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));

    assign idx      = cur_addr[IDX_W+1:2];
    assign mem_word = mem[idx];
    assign shifted  = mem_word >> {cur_addr[1:0], 3'b000};
    assign lanes    = lane_mask(cur_size, cur_addr[1:0]);

    always_comb begin
        load_data = mem_word;
        wdata_rep = cur_wdata;
        case (cur_size)
            2'b00: begin
                load_data = extend(shifted[15:0], 1'b0, cur_unsigned);
                wdata_rep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                load_data = extend(shifted[15:0], 1'b1, cur_unsigned);
                wdata_rep = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rdata_nxt = (err || cur_we) ? 32'h0 : load_data;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_nxt;
                rsp_err   <= err;
            end else if (rsp_valid && bus.rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we       <= bus.req_we;
            cap_addr     <= bus.req_addr;
            cap_size     <= bus.req_size;
            cap_unsigned <= bus.req_unsigned;
            cap_wdata    <= bus.req_wdata;
        end
    end

    // Stores commit only on the edge that enters RESP, so a reset during WAIT drops them.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state == IDLE) && reset;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 instance for the functional sequence
// and a LATENCY=0 instance for back-to-back throughput.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
    } op_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mem_responder #(.DEPTH(DEPTH), .LATENCY(0))   dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] sb_q[$];
    op_t         ops[9];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input logic err,
                               input logic [31:0] rd);
        op_t o;
        o.we = we; o.addr = addr; o.size = size; o.uns = uns;
        o.wdata = wdata; o.err = err; o.rd = rd;
        return o;
    endfunction

    task automatic apply_b(input op_t o);
        bus_b.req_we       = o.we;
        bus_b.req_addr     = o.addr;
        bus_b.req_size     = o.size;
        bus_b.req_unsigned = o.uns;
        bus_b.req_wdata    = o.wdata;
    endtask

    // One transaction on the LATENCY=2 port; hold>0 keeps rsp_ready low for that many RESP cycles.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rd, input int hold);
        int          n;
        logic [32:0] exp;
        logic [31:0] hold_rd;
        logic        hold_err;
        sb_q.push_back({exp_err, exp_rd});
        bus_a.req_we       = we;
        bus_a.req_addr     = addr;
        bus_a.req_size     = size;
        bus_a.req_unsigned = uns;
        bus_a.req_wdata    = wdata;
        bus_a.req_valid    = 1'b1;
        bus_a.rsp_ready    = (hold == 0);
        n = 0;
        while (!bus_a.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_wait", 32'(bus_a.req_ready), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus_a.req_valid = 1'b0;
                bus_a.req_we    = ~we;
                bus_a.req_addr  = $urandom;
                bus_a.req_wdata = $urandom;
            end
        end while (!bus_a.rsp_valid && n < 20);
        check_val("latency", 32'(n), 32'(LAT + 1));
        exp = sb_q.pop_front();
        check_val("rsp_err", 32'(bus_a.rsp_err), 32'(exp[32]));
        check_val("rsp_rdata", bus_a.rsp_rdata, exp[31:0]);
        if (hold > 0) begin
            hold_rd  = bus_a.rsp_rdata;
            hold_err = bus_a.rsp_err;
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                check_val("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
                check_val("bp_rdata", bus_a.rsp_rdata, hold_rd);
                check_val("bp_err", 32'(bus_a.rsp_err), 32'(hold_err));
                check_val("bp_req_ready", 32'(bus_a.req_ready), 32'd0);
            end
            bus_a.rsp_ready = 1'b1;
        end
        @(negedge clk);
        check_val("rsp_done", 32'(bus_a.rsp_valid), 32'd0);
        check_val("back_idle", 32'(bus_a.req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, seen, idx, cyc, last_acc, n_acc, n_rsp;
        logic        advance;
        logic [32:0] exp;

        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_size = '0;
        bus_a.req_unsigned = 1'b0; bus_a.req_wdata = '0; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_size = '0;
        bus_b.req_unsigned = 1'b0; bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", bus_a.rsp_rdata, 32'h0);
        check_val("rst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
        check_val("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check_val("post_rst_req_ready", 32'(bus_a.req_ready), 32'd1);
        @(negedge clk);

        // functional sequence on the LATENCY=2 instance
        txn(1, 32'h10, SZ_W, 0, 32'hDEADBEEF, 0, 32'h0, 0);
        txn(0, 32'h10, SZ_W, 0, 32'h0, 0, 32'hDEADBEEF, 0);
        txn(1, 32'h13, SZ_B, 0, 32'h12345680, 0, 32'h0, 0);
        txn(0, 32'h13, SZ_B, 0, 32'h0, 0, 32'hFFFFFF80, 0);
        txn(0, 32'h13, SZ_B, 1, 32'h0, 0, 32'h00000080, 0);
        txn(0, 32'h10, SZ_W, 0, 32'h0, 0, 32'h80ADBEEF, 0);
        txn(1, 32'h00, SZ_W, 0, 32'h0BADF00D, 0, 32'h0, 0);
        txn(1, 32'h11, SZ_H, 0, 32'h00005555, 1, 32'h0, 0);
        txn(0, 32'h12, SZ_W, 0, 32'h0, 1, 32'h0, 0);
        txn(1, DEPTH * 4, SZ_W, 0, 32'hFFFFFFFF, 1, 32'h0, 0);
        txn(0, DEPTH * 4, SZ_W, 0, 32'h0, 1, 32'h0, 0);
        txn(0, 32'h10, SZ_X, 0, 32'h0, 1, 32'h0, 0);
        txn(0, 32'h10, SZ_W, 0, 32'h0, 0, 32'h80ADBEEF, 0);
        txn(0, 32'h00, SZ_W, 0, 32'h0, 0, 32'h0BADF00D, 0);
        txn(1, 32'h12, SZ_H, 0, 32'h0000CAFE, 0, 32'h0, 0);
        txn(0, 32'h10, SZ_W, 0, 32'h0, 0, 32'hCAFEBEEF, 0);
        txn(0, 32'h12, SZ_H, 0, 32'h0, 0, 32'hFFFFCAFE, 0);
        txn(0, 32'h10, SZ_W, 0, 32'h0, 0, 32'hCAFEBEEF, 5);

        // reset while a store waits: no response and no write
        txn(1, 32'h20, SZ_W, 0, 32'hAAAAAAAA, 0, 32'h0, 0);
        bus_a.req_we = 1'b1; bus_a.req_addr = 32'h20; bus_a.req_size = SZ_W;
        bus_a.req_wdata = 32'h12345678; bus_a.req_valid = 1'b1; bus_a.rsp_ready = 1'b1;
        n = 0;
        while (!bus_a.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_val("rst_wait_req_ready", 32'(bus_a.req_ready), 32'd0);
        check_val("rst_wait_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.rsp_valid) seen++;
        end
        check_val("rst_wait_no_rsp", 32'(seen), 32'd0);
        txn(0, 32'h20, SZ_W, 0, 32'h0, 0, 32'hAAAAAAAA, 0);

        // back-to-back traffic on the LATENCY=0 instance
        ops[0] = mk(1, 32'h0, SZ_W, 0, 32'h11223344, 0, 32'h0);
        ops[1] = mk(1, 32'h4, SZ_W, 0, 32'h8899AABB, 0, 32'h0);
        ops[2] = mk(0, 32'h0, SZ_W, 0, 32'h0, 0, 32'h11223344);
        ops[3] = mk(0, 32'h6, SZ_H, 0, 32'h0, 0, 32'hFFFF8899);
        ops[4] = mk(0, 32'h4, SZ_H, 1, 32'h0, 0, 32'h0000AABB);
        ops[5] = mk(0, 32'h1, SZ_B, 0, 32'h0, 0, 32'h00000033);
        ops[6] = mk(0, 32'h7, SZ_B, 0, 32'h0, 0, 32'hFFFFFF88);
        ops[7] = mk(0, 32'h2, SZ_W, 0, 32'h0, 1, 32'h0);
        ops[8] = mk(0, 32'h4, SZ_W, 0, 32'h0, 0, 32'h8899AABB);
        idx = 0; cyc = 0; last_acc = -10; n_acc = 0; n_rsp = 0; advance = 1'b0;
        apply_b(ops[0]);
        bus_b.req_valid = 1'b1;
        bus_b.rsp_ready = 1'b1;
        while (n_rsp < 9 && cyc < 200) begin
            if (bus_b.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("l0_spurious_rsp", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp = sb_q.pop_front();
                    check_val("l0_rsp_err", 32'(bus_b.rsp_err), 32'(exp[32]));
                    check_val("l0_rsp_rdata", bus_b.rsp_rdata, exp[31:0]);
                    check_val("l0_latency", 32'(cyc - last_acc), 32'd1);
                end
                n_rsp++;
            end
            if (bus_b.req_valid && bus_b.req_ready) begin
                sb_q.push_back({ops[idx].err, ops[idx].rd});
                if (n_acc > 0) check_val("l0_spacing", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                n_acc++;
                advance = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (advance) begin
                advance = 1'b0;
                idx++;
                if (idx < 9) apply_b(ops[idx]);
                else         bus_b.req_valid = 1'b0;
            end
        end
        check_val("l0_rsp_count", 32'(n_rsp), 32'd9);
        check_val("l0_acc_count", 32'(n_acc), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
